// File: rtl/add16_sched_pkg.sv
// Shared types for the round-robin 16-bit adder scheduler.
// Holds the scheduler state encoding and the datapath width.
package add16_sched_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

endpackage

// File: rtl/add16bit_fast.sv
// 16-bit carry-lookahead adder built from four 4-bit groups.
// Group generate/propagate terms produce each group's carry-in without rippling through its bits.
module add16bit_fast (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic        group_c;
    logic        bit_c;
    logic        gg;
    logic        gp;

    always_comb begin
        g       = a & b;
        p       = a ^ b;
        sum     = '0;
        group_c = cin;
        bit_c   = 1'b0;
        gg      = 1'b0;
        gp      = 1'b0;
        for (int k = 0; k < 4; k++) begin
            gg = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp = &p[4*k +: 4];
            bit_c = group_c;
            for (int j = 0; j < 4; j++) begin
                sum[4*k+j] = p[4*k+j] ^ bit_c;
                bit_c      = g[4*k+j] | (p[4*k+j] & bit_c);
            end
            group_c = gg | (gp & group_c);
        end
        cout = group_c;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or above rr_ptr, wrapping.
// Rotating the request vector lets a fixed-priority scan do the round-robin search.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [ID_W-1:0]  winner,
    output logic             valid
);

    logic [N_REQ-1:0] rotated;

    // rotated[i] is the request that sits i places after rr_ptr; scanning downward
    // makes the lowest offset the last and therefore winning assignment.
    always_comb begin
        rotated = N_REQ'({req, req} >> rr_ptr);
        valid   = |rotated;
        winner  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                winner = ID_W'((int'(rr_ptr) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/add16_rr_sched.sv
// Shares one add16bit_fast between N_REQ requesters with round-robin arbitration.
// The winner's operands are latched, added in EXEC, and the sum is returned with its id in RESP.
module add16_rr_sched
    import add16_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [DATA_W*N_REQ-1:0] A_in,
    input  logic [DATA_W*N_REQ-1:0] B_in,
    input  logic [N_REQ-1:0]        Cin_in,
    output logic [N_REQ-1:0]        gnt,
    output logic                    busy,
    output logic                    done,
    output logic [ID_W-1:0]         done_id,
    output logic [DATA_W-1:0]       Y,
    output logic                    Cout
);

    sched_state_t      state;
    sched_state_t      state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   owner;
    logic              arb_valid;
    logic              capture;
    logic [DATA_W-1:0] a_lat;
    logic [DATA_W-1:0] b_lat;
    logic              cin_lat;
    logic [DATA_W-1:0] sum;
    logic              carry;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (winner),
        .valid  (arb_valid)
    );

    add16bit_fast u_add (
        .a    (a_lat),
        .b    (b_lat),
        .cin  (cin_lat),
        .sum  (sum),
        .cout (carry)
    );

    // Requests are only looked at while the adder is free, i.e. never during EXEC.
    assign capture = arb_valid && (state == IDLE || state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, RESP: state_next = arb_valid ? EXEC : IDLE;
            EXEC:       state_next = RESP;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        gnt  = '0;
        case (state)
            EXEC: begin
                busy = 1'b1;
                gnt  = N_REQ'(1) << owner;
            end
            RESP:    done = 1'b1;
            default: ;
        endcase
    end

    // Only the winner's slice is ever sampled, so junk on idle requesters never reaches the adder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_lat   <= '0;
            b_lat   <= '0;
            cin_lat <= 1'b0;
            owner   <= '0;
            rr_ptr  <= '0;
            Y       <= '0;
            Cout    <= 1'b0;
            done_id <= '0;
        end else begin
            if (capture) begin
                a_lat   <= A_in[DATA_W*winner +: DATA_W];
                b_lat   <= B_in[DATA_W*winner +: DATA_W];
                cin_lat <= Cin_in[winner];
                owner   <= winner;
                rr_ptr  <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
            end
            if (state == EXEC) begin
                Y       <= sum;
                Cout    <= carry;
                done_id <= owner;
            end
        end
    end

endmodule
